// File: rtl/bsg_mem_3r1w_sync_client_if.sv
// Request/response and write bus between a 3r1w RAM client and its user.
// Suffixes are from the client's point of view.
interface bsg_mem_3r1w_sync_client_if #(
  parameter int width_p      = 8,
  parameter int addr_width_p = 4
);

  logic                      w_v_i;
  logic [addr_width_p-1:0]   w_addr_i;
  logic [width_p-1:0]        w_data_i;
  logic                      r_v_i;
  logic                      r_ready_and_o;
  logic [2:0]                r_en_i;
  logic [3*addr_width_p-1:0] r_addr_i;
  logic                      r_v_o;
  logic [3*width_p-1:0]      r_data_o;
  logic                      r_yumi_i;

  modport slave (
    input  w_v_i, w_addr_i, w_data_i, r_v_i, r_en_i, r_addr_i, r_yumi_i,
    output r_ready_and_o, r_v_o, r_data_o
  );

  modport master (
    output w_v_i, w_addr_i, w_data_i, r_v_i, r_en_i, r_addr_i, r_yumi_i,
    input  r_ready_and_o, r_v_o, r_data_o
  );

endinterface

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with synchronous active-high reset to a constant value.
module bsg_dff_reset_en #(
  parameter int               width_p     = 1,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      data_reg <= reset_val_p;
    else if (en_i)
      data_reg <= data_i;
  end

  assign data_o = data_reg;

endmodule

// File: rtl/bsg_mem_3r1w_sync_client_lane.sv
// One read operand: write-collision bypass, RAM read issue, and response hold.
module bsg_mem_3r1w_sync_client_lane #(
  parameter int width_p      = 8,
  parameter int addr_width_p = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    accept_i,
  input  logic                    r_en_i,
  input  logic [addr_width_p-1:0] r_addr_i,
  input  logic                    w_v_i,
  input  logic [addr_width_p-1:0] w_addr_i,
  input  logic [width_p-1:0]      w_data_i,
  input  logic                    held_i,
  input  logic                    hold_en_i,
  output logic                    mem_v_o,
  output logic [addr_width_p-1:0] mem_addr_o,
  input  logic [width_p-1:0]      mem_data_i,
  output logic [width_p-1:0]      data_o
);

  logic               conflict;
  logic [1:0]         ctl_reg;
  logic               en_reg;
  logic               byp_sel_reg;
  logic [width_p-1:0] byp_data_reg;
  logic [width_p-1:0] hold_data_reg;
  logic [width_p-1:0] fresh_data;

  // A same-cycle write to our address wins; the RAM read is skipped entirely.
  assign conflict   = r_en_i & w_v_i & (r_addr_i == w_addr_i);
  assign mem_v_o    = accept_i & r_en_i & ~conflict;
  assign mem_addr_o = r_addr_i;

  bsg_dff_reset_en #(.width_p(2)) ctl_dff (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (accept_i),
    .data_i  ({r_en_i, conflict}),
    .data_o  (ctl_reg)
  );
  assign en_reg      = ctl_reg[1];
  assign byp_sel_reg = ctl_reg[0];

  bsg_dff_reset_en #(.width_p(width_p)) byp_dff (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (accept_i & conflict),
    .data_i  (w_data_i),
    .data_o  (byp_data_reg)
  );

  assign fresh_data = en_reg ? (byp_sel_reg ? byp_data_reg : mem_data_i) : '0;

  // RAM data is only valid for one cycle, so a stalled response is frozen here.
  bsg_dff_reset_en #(.width_p(width_p)) hold_dff (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (hold_en_i),
    .data_i  (fresh_data),
    .data_o  (hold_data_reg)
  );

  assign data_o = held_i ? hold_data_reg : fresh_data;

endmodule

// File: rtl/bsg_mem_3r1w_sync_client.sv
// Client controller for a 3-read/1-write synchronous RAM: write-first bypass
// on read/write collisions and a single held response slot.
module bsg_mem_3r1w_sync_client #(
  parameter int width_p       = 8,
  parameter int els_p         = 16,
  parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  bsg_mem_3r1w_sync_client_if.slave req,
  output logic                     mem_w_v_o,
  output logic [addr_width_lp-1:0] mem_w_addr_o,
  output logic [width_p-1:0]       mem_w_data_o,
  output logic                     mem_r0_v_o,
  output logic [addr_width_lp-1:0] mem_r0_addr_o,
  input  logic [width_p-1:0]       mem_r0_data_i,
  output logic                     mem_r1_v_o,
  output logic [addr_width_lp-1:0] mem_r1_addr_o,
  input  logic [width_p-1:0]       mem_r1_data_i,
  output logic                     mem_r2_v_o,
  output logic [addr_width_lp-1:0] mem_r2_addr_o,
  input  logic [width_p-1:0]       mem_r2_data_i
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FRESH = 2'd1,
    HELD  = 2'd2
  } state_e;

  state_e state_reg, state_next;
  logic   accept;
  logic   hold_en;
  logic   held;

  logic [2:0]                     mem_r_v;
  logic [addr_width_lp-1:0]       mem_r_addr [3];
  logic [width_p-1:0]             mem_r_data [3];

  assign mem_w_v_o    = req.w_v_i;
  assign mem_w_addr_o = req.w_addr_i;
  assign mem_w_data_o = req.w_data_i;

  assign req.r_v_o         = (state_reg != EMPTY);
  assign req.r_ready_and_o = ~req.r_v_o | req.r_yumi_i;

  // Requests seen while reset is asserted must not launch RAM reads.
  assign accept  = req.r_v_i & req.r_ready_and_o & ~reset_i;
  assign hold_en = (state_reg == FRESH) & ~req.r_yumi_i;
  assign held    = (state_reg == HELD);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      state_reg <= EMPTY;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:       if (accept) state_next = FRESH;
      FRESH, HELD: begin
        if (req.r_yumi_i)
          state_next = accept ? FRESH : EMPTY;
        else
          state_next = HELD;
      end
      default:     state_next = EMPTY;
    endcase
  end

  assign mem_r_data[0] = mem_r0_data_i;
  assign mem_r_data[1] = mem_r1_data_i;
  assign mem_r_data[2] = mem_r2_data_i;

  for (genvar gi = 0; gi < 3; gi++) begin : lane
    bsg_mem_3r1w_sync_client_lane #(
      .width_p      (width_p),
      .addr_width_p (addr_width_lp)
    ) lane_inst (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .accept_i   (accept),
      .r_en_i     (req.r_en_i[gi]),
      .r_addr_i   (req.r_addr_i[gi*addr_width_lp +: addr_width_lp]),
      .w_v_i      (req.w_v_i),
      .w_addr_i   (req.w_addr_i),
      .w_data_i   (req.w_data_i),
      .held_i     (held),
      .hold_en_i  (hold_en),
      .mem_v_o    (mem_r_v[gi]),
      .mem_addr_o (mem_r_addr[gi]),
      .mem_data_i (mem_r_data[gi]),
      .data_o     (req.r_data_o[gi*width_p +: width_p])
    );
  end

  assign mem_r0_v_o    = mem_r_v[0];
  assign mem_r1_v_o    = mem_r_v[1];
  assign mem_r2_v_o    = mem_r_v[2];
  assign mem_r0_addr_o = mem_r_addr[0];
  assign mem_r1_addr_o = mem_r_addr[1];
  assign mem_r2_addr_o = mem_r_addr[2];

endmodule

// File: tb/tb_bsg_mem_3r1w_sync_client.sv
// Directed bench for bsg_mem_3r1w_sync_client with a behavioural 3r1w RAM that
// returns random data whenever a port was not read the previous cycle.
module tb_bsg_mem_3r1w_sync_client;

  localparam int W = 8;
  localparam int E = 16;
  localparam int A = 4;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  bsg_mem_3r1w_sync_client_if #(.width_p(W), .addr_width_p(A)) bus ();

  logic         mem_w_v_o;
  logic [A-1:0] mem_w_addr_o;
  logic [W-1:0] mem_w_data_o;
  logic         mem_r0_v_o, mem_r1_v_o, mem_r2_v_o;
  logic [A-1:0] mem_r0_addr_o, mem_r1_addr_o, mem_r2_addr_o;
  logic [W-1:0] mem_r0_data, mem_r1_data, mem_r2_data;
  logic [2:0]   mem_rv;

  bsg_mem_3r1w_sync_client #(.width_p(W), .els_p(E)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .req           (bus),
    .mem_w_v_o     (mem_w_v_o),
    .mem_w_addr_o  (mem_w_addr_o),
    .mem_w_data_o  (mem_w_data_o),
    .mem_r0_v_o    (mem_r0_v_o),
    .mem_r0_addr_o (mem_r0_addr_o),
    .mem_r0_data_i (mem_r0_data),
    .mem_r1_v_o    (mem_r1_v_o),
    .mem_r1_addr_o (mem_r1_addr_o),
    .mem_r1_data_i (mem_r1_data),
    .mem_r2_v_o    (mem_r2_v_o),
    .mem_r2_addr_o (mem_r2_addr_o),
    .mem_r2_data_i (mem_r2_data)
  );

  assign mem_rv = {mem_r2_v_o, mem_r1_v_o, mem_r0_v_o};

  logic [W-1:0] ram    [E];
  logic [W-1:0] shadow [E];

  always @(posedge clk) begin
    if (mem_w_v_o) ram[mem_w_addr_o] <= mem_w_data_o;
    mem_r0_data <= mem_r0_v_o ? ram[mem_r0_addr_o] : W'($urandom);
    mem_r1_data <= mem_r1_v_o ? ram[mem_r1_addr_o] : W'($urandom);
    mem_r2_data <= mem_r2_v_o ? ram[mem_r2_addr_o] : W'($urandom);
  end

  int tests_run    = 0;
  int tests_failed = 0;

  function automatic logic [3*A-1:0] pack_addr(input int a2, input int a1, input int a0);
    return {A'(a2), A'(a1), A'(a0)};
  endfunction

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input int a, input logic [W-1:0] d);
    bus.w_v_i    = 1'b1;
    bus.w_addr_i = A'(a);
    bus.w_data_i = d;
    shadow[a]    = d;
    step();
    bus.w_v_i    = 1'b0;
  endtask

  task automatic test_reset;
    $display("[TB] test_reset");
    bus.w_v_i = 0; bus.w_addr_i = 0; bus.w_data_i = 0;
    bus.r_v_i = 1; bus.r_en_i = 3'b111; bus.r_addr_i = pack_addr(1, 2, 3);
    bus.r_yumi_i = 0;
    reset_i = 1;
    @(negedge clk);
    step();
    tests_run++;
    if (mem_rv !== 3'b000) begin
      tests_failed++;
      $display("FAIL rst_mem_v: got %b expected 000", mem_rv);
    end
    reset_i = 0; bus.r_v_i = 0;
    #1;
    tests_run++;
    if (bus.r_v_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_r_v: got %b expected 0", bus.r_v_o);
    end
    tests_run++;
    if (bus.r_ready_and_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_ready: got %b expected 1", bus.r_ready_and_o);
    end
  endtask

  task automatic test_write_path;
    $display("[TB] test_write_path");
    bus.w_v_i = 1; bus.w_addr_i = 4'd3; bus.w_data_i = 8'hA5;
    #1;
    tests_run++;
    if ({mem_w_v_o, mem_w_addr_o, mem_w_data_o} !== {1'b1, 4'd3, 8'hA5}) begin
      tests_failed++;
      $display("FAIL w_pass: got %b/%h/%h expected 1/3/a5", mem_w_v_o, mem_w_addr_o, mem_w_data_o);
    end
    shadow[3] = 8'hA5;
    step();
    do_write(5, 8'h5A);
    do_write(7, 8'h11);
    do_write(2, 8'h22);
  endtask

  task automatic test_basic_read;
    $display("[TB] test_basic_read");
    bus.r_v_i = 1; bus.r_en_i = 3'b111; bus.r_addr_i = pack_addr(7, 5, 3);
    #1;
    tests_run++;
    if (mem_rv !== 3'b111 || mem_w_v_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_mem_v: got %b w=%b expected 111 w=0", mem_rv, mem_w_v_o);
    end
    tests_run++;
    if ({mem_r2_addr_o, mem_r1_addr_o, mem_r0_addr_o} !== 12'h753) begin
      tests_failed++;
      $display("FAIL basic_addr: got %h expected 753",
               {mem_r2_addr_o, mem_r1_addr_o, mem_r0_addr_o});
    end
    step();
    bus.r_v_i = 0;
    #1;
    tests_run++;
    if (bus.r_v_o !== 1'b1 || bus.r_data_o !== 24'h115AA5) begin
      tests_failed++;
      $display("FAIL basic_data: got v=%b %h expected v=1 115aa5", bus.r_v_o, bus.r_data_o);
    end
    bus.r_yumi_i = 1;
    step();
    bus.r_yumi_i = 0;
    #1;
    tests_run++;
    if (bus.r_v_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_drain: got %b expected 0", bus.r_v_o);
    end
  endtask

  task automatic test_collision;
    $display("[TB] test_collision");
    bus.w_v_i = 1; bus.w_addr_i = 4'd5; bus.w_data_i = 8'hFF;
    shadow[5] = 8'hFF;
    bus.r_v_i = 1; bus.r_en_i = 3'b111; bus.r_addr_i = pack_addr(2, 5, 5);
    #1;
    tests_run++;
    if (mem_rv !== 3'b100) begin
      tests_failed++;
      $display("FAIL coll_mem_v: got %b expected 100", mem_rv);
    end
    step();
    bus.w_v_i = 0; bus.r_v_i = 0;
    #1;
    tests_run++;
    if (bus.r_v_o !== 1'b1 || bus.r_data_o !== 24'h22FFFF) begin
      tests_failed++;
      $display("FAIL coll_data: got v=%b %h expected v=1 22ffff", bus.r_v_o, bus.r_data_o);
    end
    bus.r_yumi_i = 1;
    step();
    bus.r_yumi_i = 0;
    bus.r_v_i = 1; bus.r_en_i = 3'b001; bus.r_addr_i = pack_addr(0, 0, 5);
    #1;
    tests_run++;
    if (mem_rv !== 3'b001) begin
      tests_failed++;
      $display("FAIL coll_reread_v: got %b expected 001", mem_rv);
    end
    step();
    bus.r_v_i = 0;
    #1;
    tests_run++;
    if (bus.r_data_o !== 24'h0000FF) begin
      tests_failed++;
      $display("FAIL coll_reread: got %h expected 0000ff", bus.r_data_o);
    end
    bus.r_yumi_i = 1;
    step();
    bus.r_yumi_i = 0;
  endtask

  task automatic test_backpressure;
    int           waddr [4];
    logic [W-1:0] wdata [4];
    waddr = '{3, 5, 7, 3};
    wdata = '{8'h33, 8'h55, 8'h77, 8'h3C};
    $display("[TB] test_backpressure");
    do_write(5, 8'h5A);
    bus.r_v_i = 1; bus.r_en_i = 3'b111; bus.r_addr_i = pack_addr(7, 5, 3);
    step();
    for (int i = 0; i < 4; i++) begin
      bus.w_v_i = 1; bus.w_addr_i = A'(waddr[i]); bus.w_data_i = wdata[i];
      shadow[waddr[i]] = wdata[i];
      #1;
      tests_run++;
      if (bus.r_v_o !== 1'b1 || bus.r_ready_and_o !== 1'b0 || mem_rv !== 3'b000) begin
        tests_failed++;
        $display("FAIL bp_ctl[%0d]: got v=%b rdy=%b mem_v=%b expected 1/0/000",
                 i, bus.r_v_o, bus.r_ready_and_o, mem_rv);
      end
      tests_run++;
      if (bus.r_data_o !== 24'h115AA5) begin
        tests_failed++;
        $display("FAIL bp_data[%0d]: got %h expected 115aa5", i, bus.r_data_o);
      end
      step();
    end
    bus.w_v_i = 0; bus.r_v_i = 0;
    #1;
    tests_run++;
    if (bus.r_data_o !== 24'h115AA5) begin
      tests_failed++;
      $display("FAIL bp_data_end: got %h expected 115aa5", bus.r_data_o);
    end
    bus.r_yumi_i = 1;
    step();
    bus.r_yumi_i = 0;
    #1;
    tests_run++;
    if (bus.r_v_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain: got %b expected 0", bus.r_v_o);
    end
  endtask

  task automatic test_back_to_back;
    logic [3*W-1:0] exp_prev;
    $display("[TB] test_back_to_back");
    for (int a = 8; a < 16; a++) do_write(a, W'(a * 8'h11));
    exp_prev = '0;
    for (int j = 0; j <= 8; j++) begin
      int a0, a1, a2;
      a0 = 8 + j % 8;
      a1 = 8 + (j + 3) % 8;
      a2 = 8 + (j + 5) % 8;
      bus.r_v_i    = (j < 8);
      bus.r_en_i   = 3'b111;
      bus.r_addr_i = pack_addr(a2, a1, a0);
      bus.r_yumi_i = (j > 0);
      #1;
      if (j > 0) begin
        tests_run++;
        if (bus.r_v_o !== 1'b1 || bus.r_ready_and_o !== 1'b1 || bus.r_data_o !== exp_prev) begin
          tests_failed++;
          $display("FAIL b2b_resp[%0d]: got v=%b rdy=%b %h expected 1/1 %h",
                   j - 1, bus.r_v_o, bus.r_ready_and_o, bus.r_data_o, exp_prev);
        end
      end
      if (j < 8) begin
        tests_run++;
        if (mem_rv !== 3'b111) begin
          tests_failed++;
          $display("FAIL b2b_mem_v[%0d]: got %b expected 111", j, mem_rv);
        end
      end
      exp_prev = {shadow[a2], shadow[a1], shadow[a0]};
      step();
    end
    bus.r_yumi_i = 0;
    #1;
    tests_run++;
    if (bus.r_v_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_drain: got %b expected 0", bus.r_v_o);
    end
  endtask

  task automatic test_enables_reset;
    $display("[TB] test_enables_reset");
    bus.r_v_i = 1; bus.r_en_i = 3'b010; bus.r_addr_i = pack_addr(3, 5, 7);
    #1;
    tests_run++;
    if (mem_rv !== 3'b010 || mem_r1_addr_o !== 4'd5) begin
      tests_failed++;
      $display("FAIL en_mem_v: got %b addr=%h expected 010 addr=5", mem_rv, mem_r1_addr_o);
    end
    step();
    bus.r_v_i = 0;
    #1;
    tests_run++;
    if (bus.r_data_o !== 24'h005500) begin
      tests_failed++;
      $display("FAIL en_fresh: got %h expected 005500", bus.r_data_o);
    end
    step();
    tests_run++;
    if (bus.r_v_o !== 1'b1 || bus.r_data_o !== 24'h005500) begin
      tests_failed++;
      $display("FAIL en_held: got v=%b %h expected v=1 005500", bus.r_v_o, bus.r_data_o);
    end
    reset_i = 1;
    bus.r_v_i = 1; bus.r_en_i = 3'b111;
    #1;
    tests_run++;
    if (mem_rv !== 3'b000) begin
      tests_failed++;
      $display("FAIL rst2_mem_v: got %b expected 000", mem_rv);
    end
    step();
    tests_run++;
    if (bus.r_v_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst2_r_v: got %b expected 0", bus.r_v_o);
    end
    reset_i = 0; bus.r_v_i = 0;
    step();
    tests_run++;
    if (bus.r_v_o !== 1'b0 || bus.r_ready_and_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst2_stale: got v=%b rdy=%b expected 0/1", bus.r_v_o, bus.r_ready_and_o);
    end
  endtask

  initial begin
    test_reset();
    test_write_path();
    test_basic_read();
    test_collision();
    test_backpressure();
    test_back_to_back();
    test_enables_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bsg_mem_3r1w_sync_client.md
# bsg_mem_3r1w_sync_client

Client-side port controller that drives a 3-read/1-write synchronous RAM (one write port, three synchronous read ports, read data valid the cycle after the read). It takes a 3-operand read request over a ready/valid handshake, suppresses any RAM read that collides with a same-cycle write and forwards the write data instead (write-first), and holds the one-cycle RAM read data in a response slot until the consumer takes it. Typical use: a register-file front end feeding an issue or execute stage.

## Interface
- width_p, no default (must be set): data width per entry and per operand.
- els_p, no default (must be set): number of RAM entries.
- addr_width_lp, default `BSG_SAFE_CLOG2(els_p)`: address width.
- clk_i  in  1  clock; all logic on posedge.
- reset_i  in  1  synchronous, active-high reset.
- w_v_i  in  1  write strobe; always accepted, no backpressure.
- w_addr_i  in  addr_width_lp  write address.
- w_data_i  in  width_p  write data.
- r_v_i  in  1  read request valid.
- r_ready_and_o  out  1  request accepted when r_v_i & r_ready_and_o.
- r_en_i  in  3  per-operand enable; bit k requests operand k.
- r_addr_i  in  3*addr_width_lp  operand addresses; operand k occupies slice k.
- r_v_o  out  1  response valid.
- r_data_o  out  3*width_p  operand data; disabled operands read as 0.
- r_yumi_i  in  1  consumer takes the response; legal only while r_v_o is high.
- mem_w_v_o, mem_w_addr_o, mem_w_data_o  out  1/addr_width_lp/width_p  RAM write port.
- mem_r{0,1,2}_v_o  out  1  RAM read enables.
- mem_r{0,1,2}_addr_o  out  addr_width_lp  RAM read addresses.
- mem_r{0,1,2}_data_i  in  width_p  RAM read data, valid only the cycle after the read.

## Operation
- Write path is combinational pass-through: mem_w_* = w_*, every cycle.
- r_ready_and_o = ~r_v_o | r_yumi_i. There is a single response slot, and a new request is accepted in the same cycle the old response is taken.
- On accept in cycle N, for each operand k:
  - Conflict: r_en_i[k] & w_v_i & (r_addr_i[k] == w_addr_i). mem_rk_v_o = 0, w_data_i is captured into byp_data[k], and byp_sel[k] = 1.
  - Otherwise: mem_rk_v_o = r_en_i[k], and byp_sel[k] = 0.
  - en_q[k] = r_en_i[k].
- mem_rk_v_o is 0 whenever no request is accepted. Address outputs are don't-care then and are driven from r_addr_i.
- The FSM is 2 bits, with states EMPTY, FRESH and HELD.
  - EMPTY: r_v_o = 0. Accept → FRESH.
  - FRESH (cycle N+1): r_v_o = 1. Operand k = en_q[k] ? (byp_sel[k] ? byp_data[k] : mem_rk_data_i) : 0.
    - yumi & accept → FRESH.
    - yumi & no accept → EMPTY.
    - no yumi → HELD; the presented operand values are captured into hold_data.
  - HELD: r_v_o = 1, data from hold_data.
    - yumi & accept → FRESH.
    - yumi & no accept → EMPTY.
    - otherwise stay in HELD.
- A response is a snapshot at accept time. Writes in cycle N+1 or later never alter a pending or held response.
- Writes in the accept cycle N are visible to that request (write-first).
- Out-of-range addresses are not checked; they pass through to the RAM.

## Timing
- Request-to-response latency: exactly 1 cycle (accept in N → r_v_o in N+1).
- Throughput: 1 request per cycle while r_yumi_i is held high.
- Reset: state = EMPTY, r_v_o = 0, r_ready_and_o = 1, en_q/byp_sel/hold_data = 0.
  - Reset asserted mid-operation drops any FRESH or HELD response.
  - mem_r*_v_o = 0 during reset cycles; requests presented during reset are not accepted.
- r_data_o is stable from the first r_v_o cycle until yumi.
- Multiple operands with the same address are legal. Each lane is handled independently: all are bypassed, or all read from the RAM.

## Structure
- No shared package. The state enum (EMPTY/FRESH/HELD) is local.
- Hold and bypass registers use the existing bsg_dff_reset_en.
- One natural sub-module is the per-operand lane, bsg_mem_3r1w_sync_client_lane. It holds the conflict compare, byp_data, the output mux and hold_data, and is instantiated 3 times.
- The FSM and handshake live in the top module.

## Test plan
- Basic read: preload addr 3 = 0xA5, 5 = 0x5A, 7 = 0x11. Request (3,5,7), all enabled → next cycle r_v_o = 1 and data = {0x11, 0x5A, 0xA5}. Only mem_r*_v_o is asserted in the accept cycle.
- Write/read collision:
  - Stimulus: in the same cycle, w_addr = 5, data 0xFF; request (5,5,2).
  - Required: mem_r0_v_o = mem_r1_v_o = 0 and mem_r2_v_o = 1.
  - Response: operands 0 and 1 = 0xFF.
  - A later read of addr 5 also returns 0xFF.
- Backpressure hold:
  - Stimulus: accept a request, then keep r_yumi_i low 4 cycles while writing new values to the read addresses, with the RAM model's read data randomised.
  - Required: r_data_o is unchanged and r_ready_and_o = 0 throughout. Yumi → EMPTY.
- Back-to-back streaming: 8 requests with yumi held high → one response per cycle, in order, each returning the expected data.
- Enables and reset: r_en_i = 3'b010 → operands 0 and 2 read 0, and only mem_r1_v_o fires. Then assert reset_i while HELD → r_v_o = 0 the next cycle and no stale response afterward.
